mux_page_sequencer: RTL and testbench

MUX_PAGE_SEQUENCER -- requirements
Module: mux_page_sequencer

---
 rtl/mux_page_sequencer.sv | 85 ++++++++
 tb/tb_mux_page_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mux_page_sequencer.sv
// Multiplexed display scan sequencer: steps a digit counter inside a page and
// advances pages automatically after N full scans, or loads a manual page select.
module mux_page_sequencer #(
    parameter int DIGITS = 4,
    parameter int PAGES  = 4,
    parameter int REP_W  = 4,
    localparam int DW = ($clog2(DIGITS) < 1) ? 1 : $clog2(DIGITS),
    localparam int PW = ($clog2(PAGES) < 1) ? 1 : $clog2(PAGES),
    localparam int SW = ($clog2(DIGITS*PAGES) < 1) ? 1 : $clog2(DIGITS*PAGES)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             On,
    input  logic             Mode,
    input  logic [PW-1:0]    PageSel,
    input  logic [REP_W-1:0] Repeats,
    output logic [SW-1:0]    state,
    output logic [PW-1:0]    page,
    output logic [DW-1:0]    digit,
    output logic             PageDone,
    output logic             FrameDone
);

    logic [REP_W-1:0] rep_q, rep_d, eff_rep;
    logic [PW-1:0]    page_d;
    logic [DW-1:0]    digit_d;
    logic             mode_q;
    logic             scan_wrap, pd_d, fd_d;

    // mode_q tracks the last Mode seen while scanning so a toggle clears the repeat count
    always_ff @(posedge Clk) begin
        if (Rst) begin
            page      <= '0;
            digit     <= '0;
            rep_q     <= '0;
            mode_q    <= Mode;
            PageDone  <= 1'b0;
            FrameDone <= 1'b0;
        end else if (On) begin
            page      <= page_d;
            digit     <= digit_d;
            rep_q     <= rep_d;
            mode_q    <= Mode;
            PageDone  <= pd_d;
            FrameDone <= fd_d;
        end else begin
            PageDone  <= 1'b0;
            FrameDone <= 1'b0;
        end
    end

    always_comb begin
        scan_wrap = (digit == DW'(DIGITS-1));
        eff_rep   = (Repeats == '0) ? REP_W'(1) : Repeats;
        digit_d   = scan_wrap ? '0 : digit + DW'(1);
        page_d    = page;
        rep_d     = rep_q;
        if (scan_wrap) begin
            if (!Mode) begin
                // widened compare so a saturated count still forces the advance
                if (({1'b0, rep_q} + (REP_W+1)'(1)) >= {1'b0, eff_rep}) begin
                    page_d = (page == PW'(PAGES-1)) ? '0 : page + PW'(1);
                    rep_d  = '0;
                end else if (rep_q != '1) begin
                    rep_d = rep_q + REP_W'(1);
                end
            end else begin
                page_d = (PageSel > PW'(PAGES-1)) ? PW'(PAGES-1) : PageSel;
                rep_d  = '0;
            end
        end else if (Mode) begin
            rep_d = '0;
        end
        if (Mode != mode_q)
            rep_d = '0;
    end

    always_comb begin
        pd_d = (page_d != page);
        fd_d = pd_d && !Mode && (page == PW'(PAGES-1)) && (page_d == '0);
    end

    assign state = SW'(page) * SW'(DIGITS) + SW'(digit);

endmodule

// File: tb/tb_mux_page_sequencer.sv
// Bench for mux_page_sequencer: a 4x4 instance and a 3-digit/5-page instance
// (exercises the manual-select clamp) share one stimulus and one reference model.
module tb_mux_page_sequencer;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst, On, Mode;
    logic [2:0] sel;
    logic [3:0] Repeats;

    logic [3:0] st0; logic [1:0] pg0, dg0; logic pd0, fd0;
    logic [3:0] st1; logic [2:0] pg1; logic [1:0] dg1; logic pd1, fd1;

    mux_page_sequencer #(.DIGITS(4), .PAGES(4), .REP_W(4)) u0 (
        .Clk(Clk), .Rst(Rst), .On(On), .Mode(Mode), .PageSel(sel[1:0]), .Repeats(Repeats),
        .state(st0), .page(pg0), .digit(dg0), .PageDone(pd0), .FrameDone(fd0));

    mux_page_sequencer #(.DIGITS(3), .PAGES(5), .REP_W(4)) u1 (
        .Clk(Clk), .Rst(Rst), .On(On), .Mode(Mode), .PageSel(sel), .Repeats(Repeats),
        .state(st1), .page(pg1), .digit(dg1), .PageDone(pd1), .FrameDone(fd1));

    int tests = 0, fails = 0;
    int D[2] = '{4, 3};
    int P[2] = '{4, 5};
    int mp[2], md[2], mr[2], mpd[2], mfd[2];
    int mprev;
    int frames, pages;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (Rst) begin
                mp[i] = 0; md[i] = 0; mr[i] = 0; mpd[i] = 0; mfd[i] = 0;
            end else if (!On) begin
                mpd[i] = 0; mfd[i] = 0;
            end else begin
                int  np, nr, s, eff;
                bit  wrap;
                wrap  = (md[i] == D[i] - 1);
                md[i] = (md[i] + 1) % D[i];
                np    = mp[i];
                nr    = mr[i];
                s     = (i == 0) ? int'(sel) % 4 : int'(sel);
                if (wrap && !Mode) begin
                    eff = (Repeats == 0) ? 1 : int'(Repeats);
                    if (mr[i] + 1 >= eff) begin
                        np = (mp[i] + 1) % P[i];
                        nr = 0;
                    end else begin
                        nr = (mr[i] < 15) ? mr[i] + 1 : 15;
                    end
                end else if (wrap) begin
                    np = (s > P[i] - 1) ? P[i] - 1 : s;
                end
                if (Mode || (int'(Mode) != mprev)) nr = 0;
                mpd[i] = (np != mp[i]);
                mfd[i] = (np != mp[i]) && !Mode && (mp[i] == P[i] - 1) && (np == 0);
                mp[i]  = np;
                mr[i]  = nr;
            end
        end
        if (Rst || On) mprev = Mode;
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check("state0", st0, mp[0]*D[0] + md[0]);
        check("page0",  pg0, mp[0]);
        check("digit0", dg0, md[0]);
        check("pdone0", pd0, mpd[0]);
        check("fdone0", fd0, mfd[0]);
        check("state1", st1, mp[1]*D[1] + md[1]);
        check("page1",  pg1, mp[1]);
        check("digit1", dg1, md[1]);
        check("pdone1", pd1, mpd[1]);
        check("fdone1", fd1, mfd[1]);
        if (fd0) frames++;
        if (pd0) pages++;
    endtask

    initial begin
        Rst = 1'b1; On = 1'b0; Mode = 1'b0; sel = '0; Repeats = 4'd3;
        step(); step();
        check("reset_state", st0, 0);

        // three scans per page, one full frame
        Rst = 1'b0; On = 1'b1; frames = 0;
        repeat (48) step();
        check("r3_frames", frames, 1);
        check("r3_end_state", st0, 0);

        // Repeats=0 behaves as 1
        Repeats = 4'd0; pages = 0;
        repeat (16) step();
        check("r0_pagedone_count", pages, 4);

        // manual select lands only at the scan wrap; out-of-range select clamps
        Rst = 1'b1; step();
        Rst = 1'b0; step();
        Mode = 1'b1; sel = 3'd2;
        step(); step();
        check("manual_no_early", st0, 3);
        step();
        check("manual_page2", st0, 8);
        sel = 3'd7;
        repeat (4) step();
        check("clamp_u0", pg0, 3);
        check("clamp_u1", pg1, 4);

        // hold with On=0
        Rst = 1'b1; Mode = 1'b0; Repeats = 4'd1; step();
        Rst = 1'b0;
        repeat (6) step();
        check("at_state6", st0, 6);
        On = 1'b0; pages = 0; frames = 0;
        repeat (5) step();
        check("hold_state", st0, 6);
        check("hold_pulses", pages + frames, 0);
        On = 1'b1; step();
        check("resume_state", st0, 7);

        // reset mid-scan with On=1
        repeat (6) step();
        check("at_state13", st0, 13);
        Rst = 1'b1; step();
        check("rst_state", st0, 0);
        Rst = 1'b0; step();
        check("post_rst_state", st0, 1);

        // lowering Repeats mid-page advances at the next wrap
        Rst = 1'b1; Repeats = 4'd5; step();
        Rst = 1'b0;
        repeat (5) step();
        Repeats = 4'd1;
        step(); step();
        check("lower_rep_pending", pg0, 0);
        step();
        check("lower_rep_advance", pg0, 1);

        // random soak against the model
        for (int n = 0; n < 800; n++) begin
            Rst = ($urandom_range(0, 79) == 0);
            On  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) Mode = ~Mode;
            if ($urandom_range(0, 9) == 0) Repeats = 4'($urandom_range(0, 15));
            sel = 3'($urandom_range(0, 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
